tag_alloc: RTL and testbench

//   Free-list allocator for LoongArch core tags such as ROB/LSQ/physical-register IDs.

---
 rtl/tag_alloc.sv | 108 ++++++++++
 tb/tb_tag_alloc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tag_alloc.sv
// Free-list tag allocator: lowest-free-index grant, release by binary index, flush returns every tag.
// Optional double-free sticky error checking is built only when TAG_ALLOC_ERR_CHK_EN is defined.
module tag_alloc #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_vld,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             flush,
  output logic [IDX_W:0]   free_cnt,
  output logic             empty,
  output logic             full,
  output logic             dbl_free_err
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] r_free_map;
  logic [IDX_W:0]         r_free_cnt;
  logic                   r_empty;
  logic                   r_full;

  logic [IDX_W-1:0]       w_alloc_idx;
  logic                   w_gnt;
  logic [NUM_ENTRIES-1:0] w_gnt_oh;
  logic [NUM_ENTRIES-1:0] w_free_oh;
  logic                   w_dbl_free;
  logic                   w_set;
  logic [NUM_ENTRIES-1:0] w_map_nxt;
  logic [IDX_W:0]         w_cnt_nxt;

  // Priority encoder: scanning from the top lets the lowest free index win.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_free_map[i]) w_alloc_idx = IDX_W'(i);
    end
  end

  assign w_gnt      = rst_n & alloc_req & ~r_empty & ~flush;
  assign w_gnt_oh   = w_gnt ? (NUM_ENTRIES'(1) << w_alloc_idx) : '0;
  assign w_free_oh  = NUM_ENTRIES'(1) << free_idx;
  assign w_dbl_free = free_vld & r_free_map[free_idx];
  // A double free never sets a bit, so the grant wins when both name the same tag.
  assign w_set      = free_vld & ~w_dbl_free;

  always_comb begin
    w_map_nxt = r_free_map & ~w_gnt_oh;
    if (w_set) w_map_nxt = w_map_nxt | w_free_oh;
  end

  always_comb begin
    w_cnt_nxt = r_free_cnt;
    if (w_set && !w_gnt)      w_cnt_nxt = r_free_cnt + 1'b1;
    else if (w_gnt && !w_set) w_cnt_nxt = r_free_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_map <= '1;
      r_free_cnt <= CNT_MAX;
      r_empty    <= 1'b0;
      r_full     <= 1'b1;
    end else if (flush) begin
      r_free_map <= '1;
      r_free_cnt <= CNT_MAX;
      r_empty    <= 1'b0;
      r_full     <= 1'b1;
    end else begin
      r_free_map <= w_map_nxt;
      r_free_cnt <= w_cnt_nxt;
      r_empty    <= (w_cnt_nxt == '0);
      r_full     <= (w_cnt_nxt == CNT_MAX);
    end
  end

`ifdef TAG_ALLOC_ERR_CHK_EN
  logic r_err;

  // Sticky until reset; a free discarded by flush is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_dbl_free && !flush) begin
      r_err <= 1'b1;
`ifndef SYNTHESIS
      $error("tag_alloc: double free of tag %0d", free_idx);
`endif
    end
  end

  assign dbl_free_err = r_err;
`else
  assign dbl_free_err = 1'b0;
`endif

  assign alloc_gnt = w_gnt;
  assign alloc_idx = w_alloc_idx;
  assign free_cnt  = r_free_cnt;
  assign empty     = r_empty;
  assign full      = r_full;

endmodule

// File: tb/tb_tag_alloc.sv
// Scoreboard bench for tag_alloc with 8 entries: directed steps push expected
// observations, a monitor pops and compares them on each falling edge.
module tb_tag_alloc;

  localparam int N  = 8;
  localparam int IW = 3;
`ifdef TAG_ALLOC_ERR_CHK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_req = 1'b0;
  logic          alloc_gnt;
  logic [IW-1:0] alloc_idx;
  logic          free_vld = 1'b0;
  logic [IW-1:0] free_idx = '0;
  logic          flush = 1'b0;
  logic [IW:0]   free_cnt;
  logic          empty;
  logic          full;
  logic          dbl_free_err;

  tag_alloc #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .free_vld(free_vld), .free_idx(free_idx), .flush(flush),
    .free_cnt(free_cnt), .empty(empty), .full(full), .dbl_free_err(dbl_free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic     gnt;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic     emp;
    logic     ful;
    logic     err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic err_seen = 1'b0;

  task automatic check(input string nm, input string fld, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expected record per observed cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, "gnt", int'(alloc_gnt), int'(e.gnt));
        check(e.name, "idx", int'(alloc_idx), int'(e.idx));
        check(e.name, "cnt", int'(free_cnt), int'(e.cnt));
        check(e.name, "empty", int'(empty), int'(e.emp));
        check(e.name, "full", int'(full), int'(e.ful));
        check(e.name, "err", int'(dbl_free_err), int'(e.err));
      end
    end
  end

  task automatic step(input string nm, input logic rq, input logic fv, input int fi,
                      input logic fl, input logic eg, input int ei, input int ec,
                      input logic ee, input logic ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    alloc_req = rq;
    free_vld  = fv;
    free_idx  = IW'(fi);
    flush     = fl;
    e.name = nm; e.gnt = eg; e.idx = 3'(ei); e.cnt = 4'(ec);
    e.emp = ee; e.ful = ef; e.err = err_seen;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   budget;
    repeat (3) @(posedge clk);
    step("reset", 0, 0, 0, 0, 0, 0, 8, 0, 1);

    for (int i = 0; i < 8; i++)
      step("fill", 1, 0, 0, 0, 1, i, 8 - i, 0, i == 0);
    step("drained", 1, 0, 0, 0, 0, 0, 0, 1, 0);

    step("nobypass", 1, 1, 5, 0, 0, 0, 0, 1, 0);
    step("regrant5", 1, 0, 0, 0, 1, 5, 1, 0, 0);
    step("empty2", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    step("flushgnt", 1, 0, 0, 1, 0, 0, 0, 1, 0);
    step("postflush", 0, 0, 0, 0, 0, 0, 8, 0, 1);

    for (int i = 0; i < 4; i++)
      step("alloc4", 1, 0, 0, 0, 1, i, 8 - i, 0, i == 0);
    step("allocfree", 1, 1, 1, 0, 1, 4, 4, 0, 0);
    step("realloc1", 1, 0, 0, 0, 1, 1, 4, 0, 0);
    step("hold", 0, 0, 0, 0, 0, 5, 3, 0, 0);

    step("flush2", 0, 0, 0, 1, 0, 5, 3, 0, 0);
    step("dblfree", 0, 1, 2, 0, 0, 0, 8, 0, 1);
    err_seen = ERR_ON;
    step("errflush", 0, 0, 0, 1, 0, 0, 8, 0, 1);
    step("errhold", 0, 0, 0, 0, 0, 0, 8, 0, 1);

    step("samedbl", 1, 1, 0, 0, 1, 0, 8, 0, 1);
    step("grantwon", 0, 0, 0, 0, 0, 1, 7, 0, 0);

    step("flush3", 0, 0, 0, 1, 0, 1, 7, 0, 0);
    for (int i = 0; i < 6; i++)
      step("alloc6", 1, 0, 0, 0, 1, i, 8 - i, 0, i == 0);

    // Asynchronous reset asserted between edges with a request pending.
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    free_vld  = 1'b0;
    flush     = 1'b0;
    err_seen  = 1'b0;
    e.name = "midreset"; e.gnt = 0; e.idx = 0; e.cnt = 8; e.emp = 0; e.ful = 1; e.err = 0;
    q.push_back(e);
    step("afterreset", 1, 0, 0, 0, 1, 0, 8, 0, 1);
    step("idle", 0, 0, 0, 0, 0, 1, 7, 0, 0);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
